// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES state types, MixColumns FSM encoding and column helpers.
// Rev     : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NB = 4;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Column 0 occupies the most significant word of the state.
    function automatic aes_col_t get_col(aes_state_t state, logic [1:0] idx);
        return state[127 - 32*idx -: 32];
    endfunction

    function automatic aes_state_t set_col(aes_state_t state, logic [1:0] idx, aes_col_t col);
        aes_state_t r;
        r = state;
        r[127 - 32*idx -: 32] = col;
        return r;
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixcolumns_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : mixcolumns_seq_if
// Brief   : Input and output valid/ready channels of the MixColumns sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface mixcolumns_seq_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    logic       in_bypass;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;

    modport master (
        output in_valid, in_state, in_bypass, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_bypass, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface
`default_nettype wire

// File: rtl/MixColumns.sv
`default_nettype none
// ============================================================================
// Module  : MixColumns
// Brief   : Combinational single-column AES MixColumns (s0 is the MSB byte).
// Rev     : 1.0  initial release
// ============================================================================
module MixColumns
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    output aes_col_t col_out
);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;

    assign {a0, a1, a2, a3} = col_in;

    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);

    // 3*x is formed as xtime(x) ^ x.
    assign col_out[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
    assign col_out[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
endmodule
`default_nettype wire

// File: rtl/mixcolumns_seq.sv
`default_nettype none
// ============================================================================
// Module  : mixcolumns_seq
// Brief   : Time-shares COLS_PER_CYCLE MixColumns units over a 128-bit state.
// Rev     : 1.0  initial release
// ============================================================================
module mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mixcolumns_seq_if.slave   bus,
    output logic              busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
        begin : g_bad_cols
            $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    mc_state_e   fsm;
    aes_state_t  state_reg;
    aes_state_t  mixed;
    logic [1:0]  col_idx;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        last_col;

    logic [1:0]  col_sel [COLS_PER_CYCLE];
    aes_col_t    mix_in  [COLS_PER_CYCLE];
    aes_col_t    mix_out [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
            assign col_sel[g] = col_idx + 2'(g);
            assign mix_in[g]  = get_col(state_reg, col_sel[g]);

            MixColumns u_mix (
                .col_in  (mix_in[g]),
                .col_out (mix_out[g])
            );
        end
    endgenerate

    // Only the selected columns change; the rest pass through untouched.
    always_comb begin
        mixed = state_reg;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            mixed = set_col(mixed, col_sel[i], mix_out[i]);
        end
    end

    assign last_col = (col_sel[COLS_PER_CYCLE-1] == 2'(AES_NB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= MC_IDLE;
            state_reg     <= '0;
            col_idx       <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (fsm)
                MC_IDLE: begin
                    if (bus.in_valid) begin
                        state_reg    <= bus.in_state;
                        col_idx      <= 2'd0;
                        in_ready_reg <= 1'b0;
                        if (bus.in_bypass) begin
                            fsm           <= MC_DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            fsm  <= MC_BUSY;
                            busy <= 1'b1;
                        end
                    end
                end
                MC_BUSY: begin
                    state_reg <= mixed;
                    col_idx   <= col_idx + 2'(COLS_PER_CYCLE);
                    if (last_col) begin
                        fsm           <= MC_DONE;
                        busy          <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                MC_DONE: begin
                    if (bus.out_ready) begin
                        fsm           <= MC_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    fsm           <= MC_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_state = state_reg;

endmodule
`default_nettype wire
